// File: rtl/req_onehot_arbiter.sv
// Request front end for the 8x3 encoder: synchronises async request lines,
// latches rising edges as pending events and issues them one at a time, round-robin.
module req_onehot_arbiter #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] grant,
  output logic [N-1:0] pending,
  output logic         overflow,
  input  logic         clr_ovf
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  hist_q;
  logic [N-1:0]                  rise_c;

  state_e        state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic          pick_found_c;
  logic [PW-1:0] pick_idx_c;
  logic [N-1:0]  accept_mask_c;
  int unsigned   scan_idx;

  // Synchroniser chain plus one history stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= req;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Round-robin pick: first registered pending bit at or above rr_ptr, wrapping modulo N
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    scan_idx     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      scan_idx = 32'(rr_ptr_q) + off;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (!pick_found_c && pending_q[PW'(scan_idx)]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    accept_mask_c = '0;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        grant_d     = '0;
        if (pick_found_c) begin
          sel_d       = pick_idx_c;
          grant_d     = N'(1) << pick_idx_c;
          out_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (out_valid_q && out_ready) begin
          accept_mask_c = grant_q;
          rr_ptr_d      = (sel_q == PW'(N - 1)) ? '0 : sel_q + PW'(1);
          out_valid_d   = 1'b0;
          grant_d       = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        grant_d     = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // New edges win over a same-cycle accept and over a same-cycle overflow clear
  always_comb begin
    pending_d  = (pending_q & ~accept_mask_c) | rise_c;
    overflow_d = (overflow_q & ~clr_ovf) | (|(rise_c & pending_q & ~accept_mask_c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Directed bench for req_onehot_arbiter: reset, latency, round-robin, hold, overflow, set-wins.
module tb_req_onehot_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] grant;
  logic [7:0] pending;
  logic       overflow;
  logic       clr_ovf;

  int checks;
  int failures;

  req_onehot_arbiter #(.N(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .grant     (grant),
    .pending   (pending),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    tick(2);
    check("rst_valid",    32'(out_valid), 32'h0);
    check("rst_grant",    32'(grant),     32'h0);
    check("rst_pending",  32'(pending),   32'h0);
    check("rst_overflow", 32'(overflow),  32'h0);
    rst = 1'b0;
    tick(1);

    // Single request, latency of four edges, accepted on first cycle
    req = 8'h08; out_ready = 1'b1;
    tick(3);
    check("t2_pend_before_valid", 32'(pending),   32'h08);
    check("t2_valid_early",       32'(out_valid), 32'h0);
    tick(1);
    check("t2_valid",  32'(out_valid), 32'h1);
    check("t2_grant",  32'(grant),     32'h08);
    tick(1);
    check("t2_valid_drop", 32'(out_valid), 32'h0);
    check("t2_grant_drop", 32'(grant),     32'h00);
    check("t2_pend_clear", 32'(pending),   32'h00);

    // Reset mid-grant with two events pending (rr_ptr=4 -> bit 0 first)
    req = 8'h00; out_ready = 1'b0;
    tick(4);
    req = 8'h05;
    tick(4);
    check("t1_grant_pre",   32'(grant),   32'h01);
    check("t1_pending_pre", 32'(pending), 32'h05);
    rst = 1'b1; req = 8'h00;
    #1;
    check("t1_valid",    32'(out_valid), 32'h0);
    check("t1_grant",    32'(grant),     32'h0);
    check("t1_pending",  32'(pending),   32'h0);
    check("t1_overflow", 32'(overflow),  32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Two simultaneous edges, round-robin from rr_ptr=0, wrap back to 0
    req = 8'h81; out_ready = 1'b1;
    tick(3);
    check("t3_pending", 32'(pending), 32'h81);
    tick(1);
    check("t3_grant_a", 32'(grant), 32'h01);
    tick(1);
    check("t3_gap",     32'(out_valid), 32'h0);
    check("t3_pend_b",  32'(pending),   32'h80);
    tick(1);
    check("t3_grant_b", 32'(grant), 32'h80);
    tick(1);
    check("t3_pend_empty", 32'(pending), 32'h00);
    req = 8'h00;
    tick(4);
    req = 8'h81;
    tick(4);
    check("t3_wrap_grant", 32'(grant), 32'h01);
    tick(2);
    check("t3_wrap_grant_b", 32'(grant), 32'h80);
    tick(1);

    // Grant held stable under backpressure while another request arrives
    req = 8'h00; out_ready = 1'b0;
    tick(4);
    req = 8'h04;
    tick(4);
    check("t4_grant", 32'(grant), 32'h04);
    req = 8'h44;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t4_hold", {23'h0, out_valid, grant}, {23'h0, 1'b1, 8'h04});
    end
    check("t4_pending", 32'(pending), 32'h44);
    out_ready = 1'b1;
    tick(1);
    check("t4_idle", {23'h0, out_valid, grant}, 32'h0);
    out_ready = 1'b0;
    tick(1);
    check("t4_next", {23'h0, out_valid, grant}, {23'h0, 1'b1, 8'h40});
    out_ready = 1'b1;
    tick(1);

    // Repeated edge on a pending bit sets sticky overflow
    req = 8'h00; out_ready = 1'b0;
    tick(4);
    req = 8'h08;
    tick(4);
    check("t5_grant",    32'(grant),    32'h08);
    check("t5_no_ovf",   32'(overflow), 32'h0);
    for (int i = 0; i < 2; i++) begin
      req = 8'h00;
      tick(4);
      req = 8'h08;
      tick(3);
      check("t5_ovf_set", 32'(overflow), 32'h1);
    end
    check("t5_grant_held", 32'(grant), 32'h08);
    out_ready = 1'b1;
    tick(1);
    check("t5_accepted",   32'(out_valid), 32'h0);
    check("t5_ovf_sticky", 32'(overflow),  32'h1);
    out_ready = 1'b0; clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("t5_ovf_clear", 32'(overflow), 32'h0);

    // Edge landing in the accept cycle of the same bit keeps it pending
    req = 8'h00;
    tick(4);
    req = 8'h04;
    tick(4);
    check("t6_grant", 32'(grant), 32'h04);
    req = 8'h00;
    tick(4);
    req = 8'h04;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    check("t6_accept_valid", 32'(out_valid), 32'h0);
    check("t6_pending_kept", 32'(pending),   32'h04);
    check("t6_no_ovf",       32'(overflow),  32'h0);
    out_ready = 1'b0;
    tick(1);
    check("t6_reissue", {23'h0, out_valid, grant}, {23'h0, 1'b1, 8'h04});
    out_ready = 1'b1;
    tick(1);
    check("t6_final_pending", 32'(pending), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
